// File: rtl/cnt_tx_sched_pkg.sv
// Shared types and defaults for the counter-sharing transaction scheduler.
package cnt_tx_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_WIDTH   = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } tx_packet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } sched_state_e;

endpackage

// File: rtl/cnt_tx_sched_rr_arb.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    // Scan farthest-first so the nearest set bit after ptr is the last one written.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_tx_sched.sv
// Round-robin scheduler sharing one counter between NUM_REQ requesters;
// each job runs one counter period, then offers the captured packet downstream.
//
// state | meaning
// IDLE  | waiting for any request; grant issued on the edge leaving IDLE
// RUN   | flag_cnt_o high, waiting for the counter terminal pulse
// SEND  | out_valid_o high, holding the packet until out_ready_i
module cnt_tx_sched
  import cnt_tx_sched_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int REQ_IDX_W = $clog2(NUM_REQ),
  parameter int TXCNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  tx_packet_t [NUM_REQ-1:0] pkt_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic                     clear_i,
  output logic                     flag_cnt_o,
  input  logic                     end_cnt_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output tx_packet_t               out_pkt_o,
  output logic [REQ_IDX_W-1:0]     out_src_o,
  output logic                     busy_o,
  output logic [TXCNT_W-1:0]       tx_cnt_o
);

  sched_state_e state_q, state_d;

  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [REQ_IDX_W-1:0] winner;
  logic                 any_req;

  logic [NUM_REQ-1:0]   gnt_d;
  logic                 flag_d;
  logic                 valid_d;
  tx_packet_t           pkt_d;
  logic [REQ_IDX_W-1:0] src_d;
  logic                 busy_d;
  logic [TXCNT_W-1:0]   tx_d;
  logic                 handshake;

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_rr_arb (
    .req     (req_i),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign handshake = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_IDX_W'(NUM_REQ - 1);
      gnt_o       <= '0;
      flag_cnt_o  <= 1'b0;
      out_valid_o <= 1'b0;
      out_pkt_o   <= '0;
      out_src_o   <= '0;
      busy_o      <= 1'b0;
      tx_cnt_o    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_o       <= gnt_d;
      flag_cnt_o  <= flag_d;
      out_valid_o <= valid_d;
      out_pkt_o   <= pkt_d;
      out_src_o   <= src_d;
      busy_o      <= busy_d;
      tx_cnt_o    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (any_req)   state_d = RUN;
        RUN:     if (end_cnt_i) state_d = SEND;
        SEND:    if (handshake) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; clear_i overrides every event.
  always_comb begin
    gnt_d   = '0;
    flag_d  = flag_cnt_o;
    valid_d = out_valid_o;
    pkt_d   = out_pkt_o;
    src_d   = out_src_o;
    ptr_d   = ptr_q;
    tx_d    = tx_cnt_o;
    if (clear_i) begin
      flag_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_d[winner] = 1'b1;
            pkt_d         = pkt_i[winner];
            src_d         = winner;
            ptr_d         = winner;
            flag_d        = 1'b1;
          end
        end
        RUN: begin
          if (end_cnt_i) begin
            flag_d  = 1'b0;
            valid_d = 1'b1;
          end
        end
        SEND: begin
          if (handshake) begin
            valid_d = 1'b0;
            tx_d    = tx_cnt_o + TXCNT_W'(1);
          end
        end
        default: begin
          flag_d  = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cnt_tx_sched.sv
// Directed plus randomized checks of cnt_tx_sched against a round-robin job model.
module tb_cnt_tx_sched;
  import cnt_tx_sched_pkg::*;

  localparam int N = NUM_REQ_DEF;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_i = '0;
  tx_packet_t [N-1:0] pkt_i = '0;
  logic             clear_i = 1'b0;
  logic             end_cnt_i = 1'b0;
  logic             out_ready_i = 1'b0;

  logic [N-1:0]     gnt_o;
  logic             flag_cnt_o;
  logic             out_valid_o;
  tx_packet_t       out_pkt_o;
  logic [1:0]       out_src_o;
  logic             busy_o;
  logic [15:0]      tx_cnt_o;

  logic [N-1:0]     w_gnt;
  logic             w_flag;
  logic             w_valid;
  tx_packet_t       w_pkt;
  logic [1:0]       w_src;
  logic             w_busy;
  logic [1:0]       w_tx_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int         ptr_m = N - 1;
  int         tx_m  = 0;
  tx_packet_t cur_pkt;
  int         cur_src;

  always #5 clk = ~clk;

  cnt_tx_sched u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .pkt_i       (pkt_i),
    .gnt_o       (gnt_o),
    .clear_i     (clear_i),
    .flag_cnt_o  (flag_cnt_o),
    .end_cnt_i   (end_cnt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pkt_o   (out_pkt_o),
    .out_src_o   (out_src_o),
    .busy_o      (busy_o),
    .tx_cnt_o    (tx_cnt_o)
  );

  cnt_tx_sched #(.TXCNT_W(2)) u_dut_w (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .pkt_i       (pkt_i),
    .gnt_o       (w_gnt),
    .clear_i     (clear_i),
    .flag_cnt_o  (w_flag),
    .end_cnt_i   (end_cnt_i),
    .out_valid_o (w_valid),
    .out_ready_i (out_ready_i),
    .out_pkt_o   (w_pkt),
    .out_src_o   (w_src),
    .busy_o      (w_busy),
    .tx_cnt_o    (w_tx_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (p + off) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = N - 1;
    tx_m  = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  busy_o, 1'b0);
    chk({tag, "_valid"}, out_valid_o, 1'b0);
    chk({tag, "_flag"},  flag_cnt_o, 1'b0);
    chk({tag, "_gnt"},   gnt_o, '0);
  endtask

  task automatic randomize_pkts();
    for (int i = 0; i < N; i++) begin
      pkt_i[i].addr = $urandom();
      pkt_i[i].data = $urandom();
    end
  endtask

  // Present requests while IDLE; the grant must appear on the very next edge.
  task automatic grant_phase(input logic [N-1:0] r, input bit fixed_pkt0);
    int w;
    req_i = r;
    randomize_pkts();
    if (fixed_pkt0) begin
      pkt_i[0].addr = 32'd32;
      pkt_i[0].data = 32'd83;
    end
    w = pick(r, ptr_m);
    cur_src = w;
    cur_pkt = pkt_i[w];
    step();
    chk("grant_onehot", gnt_o, 64'(1) << w);
    chk("grant_src", out_src_o, 64'(w));
    chk("grant_pkt", out_pkt_o, cur_pkt);
    chk("grant_flag", flag_cnt_o, 1'b1);
    chk("grant_busy", busy_o, 1'b1);
    ptr_m = w;
    randomize_pkts();
  endtask

  task automatic run_phase(input int period);
    step();
    chk("gnt_pulse", gnt_o, '0);
    for (int i = 1; i < period; i++) begin
      chk("run_flag", flag_cnt_o, 1'b1);
      chk("run_valid", out_valid_o, 1'b0);
      step();
    end
    chk("run_flag_last", flag_cnt_o, 1'b1);
    end_cnt_i = 1'b1;
    step();
    end_cnt_i = 1'b0;
    chk("send_valid", out_valid_o, 1'b1);
    chk("send_flag", flag_cnt_o, 1'b0);
    chk("send_pkt", out_pkt_o, cur_pkt);
    chk("send_src", out_src_o, 64'(cur_src));
    chk("send_busy", busy_o, 1'b1);
  endtask

  task automatic send_phase(input int delay, input bit spurious);
    out_ready_i = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (spurious && i == 1) end_cnt_i = 1'b1;
      step();
      end_cnt_i = 1'b0;
      chk("bp_valid", out_valid_o, 1'b1);
      chk("bp_pkt", out_pkt_o, cur_pkt);
      chk("bp_flag", flag_cnt_o, 1'b0);
      chk("bp_gnt", gnt_o, '0);
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    tx_m++;
    chk("hs_valid", out_valid_o, 1'b0);
    chk("hs_busy", busy_o, 1'b0);
    chk("hs_tx", tx_cnt_o, 64'(tx_m % 65536));
    chk("hs_tx_w", w_tx_cnt, 64'(tx_m % 4));
  endtask

  // Clear mid-RUN, optionally coinciding with the counter terminal pulse.
  task automatic abort_phase(input bit with_end);
    step();
    chk("abort_gnt_pulse", gnt_o, '0);
    clear_i   = 1'b1;
    end_cnt_i = with_end;
    step();
    clear_i   = 1'b0;
    end_cnt_i = 1'b0;
    chk("abort_flag", flag_cnt_o, 1'b0);
    chk("abort_valid", out_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_tx", tx_cnt_o, 64'(tx_m % 65536));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_pkt", out_pkt_o, '0);
    chk("reset_src", out_src_o, '0);
    chk("reset_tx", tx_cnt_o, '0);
    rst = 1'b1;
    model_reset();
    step();

    // single requester with fixed packet
    grant_phase(4'b0001, 1'b1);
    chk("first_pkt_const", out_pkt_o, {32'd32, 32'd83});
    req_i = '0;
    run_phase(4);
    send_phase(0, 1'b0);
    chk("first_tx_one", tx_cnt_o, 64'd1);

    // spurious terminal pulse while IDLE with no requests
    req_i = '0;
    end_cnt_i = 1'b1;
    step();
    end_cnt_i = 1'b0;
    check_idle_outputs("idle_spur");
    step();
    check_idle_outputs("idle_hold");

    // backpressure with a spurious terminal pulse in SEND
    grant_phase(4'b1000, 1'b0);
    run_phase(3);
    send_phase(10, 1'b1);

    // aborts: next grant follows the kept pointer
    grant_phase(4'b0010, 1'b0);
    abort_phase(1'b0);
    grant_phase(4'b0110, 1'b0);
    chk("abort_next_idx2", out_src_o, 64'd2);
    run_phase(2);
    send_phase(0, 1'b0);
    grant_phase(4'b0010, 1'b0);
    abort_phase(1'b1);
    grant_phase(4'b0010, 1'b0);
    chk("abort_next_idx1", out_src_o, 64'd1);
    run_phase(1);
    // clear coinciding with a handshake: no count
    out_ready_i = 1'b1;
    clear_i     = 1'b1;
    step();
    out_ready_i = 1'b0;
    clear_i     = 1'b0;
    chk("clr_hs_valid", out_valid_o, 1'b0);
    chk("clr_hs_busy", busy_o, 1'b0);
    chk("clr_hs_tx", tx_cnt_o, 64'(tx_m));

    // randomized jobs
    for (int it = 0; it < 30; it++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, (1 << N) - 1));
      grant_phase(r, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        abort_phase(1'(($urandom_range(0, 1))));
      end else begin
        run_phase($urandom_range(1, 6));
        send_phase($urandom_range(0, 3), 1'b0);
      end
    end

    // async reset mid-SEND
    grant_phase(4'b0100, 1'b0);
    run_phase(3);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("areset_send");
    chk("areset_tx", tx_cnt_o, '0);
    chk("areset_tx_w", w_tx_cnt, '0);
    chk("areset_pkt", out_pkt_o, '0);
    req_i = '0;
    step();
    rst = 1'b1;
    model_reset();
    step();

    // async reset mid-RUN
    grant_phase(4'b0100, 1'b0);
    step();
    #2 rst = 1'b0;
    #1;
    chk("areset_run_flag", flag_cnt_o, 1'b0);
    chk("areset_run_busy", busy_o, 1'b0);
    req_i = '0;
    step();
    rst = 1'b1;
    model_reset();
    step();

    // all requesting from reset: order 0,1,2,3,0 and 2-bit wrap
    for (int j = 0; j < 5; j++) begin
      grant_phase(4'b1111, 1'b0);
      chk("rr_order", out_src_o, 64'(j % 4));
      run_phase(2);
      send_phase(0, 1'b0);
    end
    chk("all_tx_five", tx_cnt_o, 64'd5);
    chk("wrap_tx_one", w_tx_cnt, 64'd1);
    req_i = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
